// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: debounced push-button to one-cycle SR set/reset pulse generator
module sr_cmd_gen #(
    parameter int DB_CYCLES   = 4,
    parameter int HOLD_CYCLES = 3
) (
    input  logic ck,
    input  logic rst,
    input  logic on_raw,
    input  logic off_raw,
    output logic s,
    output logic r,
    output logic busy
);
    typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, HOLD} state_t;
    state_t     state;
    logic [1:0] raw, meta, sync, filt, rise;
    logic [7:0] cnt [2];
    logic [7:0] hcnt;
    logic       pend_on, pend_off, want_on, want_off, serve;
    assign raw = {off_raw, on_raw};
    // per button: two-flop sync, then accept a new level after DB_CYCLES+1 differing samples; flag 0->1 acceptances
    always_ff @(posedge ck) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
            filt <= '0;
            rise <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            rise <= '0;
            for (int i = 0; i < 2; i++) begin
                if (sync[i] == filt[i]) cnt[i] <= '0;
                else if (cnt[i] == 8'(DB_CYCLES)) begin
                    filt[i] <= sync[i];
                    rise[i] <= sync[i];
                    cnt[i]  <= '0;
                end else cnt[i] <= cnt[i] + 8'd1;
            end
        end
    end
    // a decision point is any IDLE cycle or the last HOLD cycle, so pending work follows HOLD without a gap
    always_comb begin
        want_on  = rise[0] | pend_on;
        want_off = rise[1] | pend_off;
        serve    = (state == IDLE) || (state == HOLD && hcnt == 8'(HOLD_CYCLES - 1));
    end
    // pulse FSM with registered outputs; reset request wins over set, pending flags cleared when served
    always_ff @(posedge ck) begin
        if (rst) begin
            state    <= IDLE;
            hcnt     <= '0;
            pend_on  <= 1'b0;
            pend_off <= 1'b0;
            s        <= 1'b0;
            r        <= 1'b0;
            busy     <= 1'b0;
        end else if (serve) begin
            state    <= want_off ? PULSE_R : want_on ? PULSE_S : IDLE;
            hcnt     <= '0;
            pend_on  <= 1'b0;
            pend_off <= 1'b0;
            s        <= want_on & ~want_off;
            r        <= want_off;
            busy     <= want_on | want_off;
        end else begin
            state    <= HOLD;
            hcnt     <= (state == HOLD) ? hcnt + 8'd1 : 8'd0;
            pend_on  <= pend_on | rise[0];
            pend_off <= pend_off | rise[1];
            s        <= 1'b0;
            r        <= 1'b0;
            busy     <= 1'b1;
        end
    end
endmodule
